fft_frame_sequencer: RTL and testbench

Runtime-length, multi-frame control sequencer for the radix-2 in-place FFT core. It loads input samples at bit-reversed addresses for a selectable length of 2^cfg_log2n points. It then steps the butterfly stages through the external address generator and butterfly unit. Finally it holds results for DMA readout and, on host acknowledge, rearms for the next frame instead of locking in DONE.

---
 rtl/fft_frame_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the radix-2 in-place FFT core.
// Loads a frame of 2^log2n samples at bit-reversed addresses, then steps
// log2n butterfly stages through the external AGU / butterfly unit, then
// holds the results for DMA until the host acknowledges and the next frame
// is armed.
// Optional build macro: FFT_SEQ_OVERRUN_EN adds overrun_cnt, a saturating
// count of samples offered while the sequencer was not loading.
//
// state | meaning
// IDLE  | one cycle after reset/abort, then arm the frame length
// LOAD  | accept samples, write RAM at bit-reversed addresses
// SETUP | clear the stage index before the first stage
// RUN   | AGU issuing the current stage
// WAIT  | drain the butterfly pipeline
// NEXT  | clear BFP tracker, advance stage or finish
// DONE  | results stable for DMA, wait for host ack
module fft_frame_sequencer #(
    parameter int FFT_N       = 10,
    parameter int MIN_LOG2N   = 3,
    parameter int STAGE_W     = 4,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   abort,
    input  logic [STAGE_W-1:0]     cfg_log2n,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   load_we,
    output logic [FFT_N-1:0]       load_addr,
    output logic                   stage_start,
    output logic [STAGE_W-1:0]     stage_idx,
    output logic [STAGE_W-1:0]     log2n,
    input  logic                   agu_done,
    input  logic                   bfly_busy,
    output logic                   bfp_clr,
    output logic                   result_valid,
    input  logic                   result_ack,
    output logic [2:0]             status,
`ifdef FFT_SEQ_OVERRUN_EN
    output logic [15:0]            overrun_cnt,
`endif
    output logic [FRAME_CNT_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_RUN,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [STAGE_W-1:0] LOG2N_MIN = STAGE_W'(MIN_LOG2N);
    localparam logic [STAGE_W-1:0] LOG2N_MAX = STAGE_W'(FFT_N);

    state_t             state;
    state_t             next_state;
    logic [STAGE_W-1:0] cfg_clamped;
    logic [FFT_N-1:0]   sample_cnt;
    logic [FFT_N-1:0]   frame_mask;
    logic               sample_last;
    logic               stage_last;
    logic               accept;
    logic [2:0]         next_status;

    // Clamp the requested frame length into the supported range.
    always_comb begin
        cfg_clamped = cfg_log2n;
        if (cfg_log2n < LOG2N_MIN) begin
            cfg_clamped = LOG2N_MIN;
        end else if (cfg_log2n > LOG2N_MAX) begin
            cfg_clamped = LOG2N_MAX;
        end
    end

    // Bit-reverse the low log2n counter bits; upper address bits stay zero.
    always_comb begin
        load_addr  = '0;
        frame_mask = '0;
        for (int i = 0; i < FFT_N; i++) begin
            frame_mask[i] = (i < int'(log2n));
            for (int j = 0; j < FFT_N; j++) begin
                if ((i + j + 1) == int'(log2n)) begin
                    load_addr[i] = sample_cnt[j];
                end
            end
        end
    end

    assign accept      = (state == S_LOAD) && in_valid;
    assign load_we     = accept;
    assign sample_last = (sample_cnt == frame_mask);
    assign stage_last  = (stage_idx == (log2n - 1'b1));

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_LOAD;
            S_LOAD:  if (accept && sample_last) next_state = S_SETUP;
            S_SETUP: next_state = S_RUN;
            S_RUN:   if (agu_done) next_state = S_WAIT;
            S_WAIT:  if (!bfly_busy) next_state = S_NEXT;
            S_NEXT:  next_state = stage_last ? S_DONE : S_RUN;
            S_DONE:  if (result_ack) next_state = S_LOAD;
            default: next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state = S_IDLE;
        end
    end

    // Host-visible status code derived from the upcoming state.
    always_comb begin
        next_status = 3'd2;
        case (next_state)
            S_IDLE:  next_status = 3'd0;
            S_LOAD:  next_status = 3'd1;
            S_DONE:  next_status = 3'd3;
            default: next_status = 3'd2;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sample counter, stage index, armed length and completed-frame count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt  <= '0;
            stage_idx   <= '0;
            log2n       <= LOG2N_MIN;
            frame_count <= '0;
        end else if (abort) begin
            sample_cnt <= '0;
            stage_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: log2n <= cfg_clamped;
                S_LOAD: begin
                    if (accept) begin
                        sample_cnt <= sample_last ? '0 : sample_cnt + 1'b1;
                    end
                end
                S_SETUP: stage_idx <= '0;
                S_NEXT: begin
                    if (!stage_last) begin
                        stage_idx <= stage_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        frame_count <= frame_count + 1'b1;
                        log2n       <= cfg_clamped;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered control outputs, decoded from the state being entered so
    // they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready     <= 1'b0;
            stage_start  <= 1'b0;
            bfp_clr      <= 1'b0;
            result_valid <= 1'b0;
            status       <= 3'd0;
        end else begin
            in_ready     <= (next_state == S_LOAD);
            stage_start  <= (next_state == S_RUN) && (state != S_RUN);
            bfp_clr      <= (next_state == S_NEXT);
            result_valid <= (next_state == S_DONE);
            status       <= next_status;
        end
    end

`ifdef FFT_SEQ_OVERRUN_EN
    // Count samples offered while not loading; saturate, clear only on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_cnt <= '0;
        end else if (in_valid && (state != S_LOAD) && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer. Expected values come from a
// frame-level model: a frame of length L loads 2^L samples at bit-reversed
// addresses, runs L stages, then waits for ack.
module tb_fft_frame_sequencer;

    localparam int FFT_N       = 10;
    localparam int MIN_LOG2N   = 3;
    localparam int STAGE_W     = 4;
    localparam int FRAME_CNT_W = 8;

    logic                   clk;
    logic                   rst;
    logic                   abort;
    logic [STAGE_W-1:0]     cfg_log2n;
    logic                   in_valid;
    logic                   in_ready;
    logic                   load_we;
    logic [FFT_N-1:0]       load_addr;
    logic                   stage_start;
    logic [STAGE_W-1:0]     stage_idx;
    logic [STAGE_W-1:0]     log2n;
    logic                   agu_done;
    logic                   bfly_busy;
    logic                   bfp_clr;
    logic                   result_valid;
    logic                   result_ack;
    logic [2:0]             status;
    logic [FRAME_CNT_W-1:0] frame_count;
`ifdef FFT_SEQ_OVERRUN_EN
    logic [15:0]            overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int fc_model = 0;
    int ovr_model = 0;

    fft_frame_sequencer #(
        .FFT_N(FFT_N), .MIN_LOG2N(MIN_LOG2N), .STAGE_W(STAGE_W), .FRAME_CNT_W(FRAME_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .abort(abort), .cfg_log2n(cfg_log2n),
        .in_valid(in_valid), .in_ready(in_ready), .load_we(load_we), .load_addr(load_addr),
        .stage_start(stage_start), .stage_idx(stage_idx), .log2n(log2n),
        .agu_done(agu_done), .bfly_busy(bfly_busy), .bfp_clr(bfp_clr),
        .result_valid(result_valid), .result_ack(result_ack), .status(status),
`ifdef FFT_SEQ_OVERRUN_EN
        .overrun_cnt(overrun_cnt),
`endif
        .frame_count(frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampl(input int c);
        if (c < MIN_LOG2N) return MIN_LOG2N;
        if (c > FFT_N) return FFT_N;
        return c;
    endfunction

    function automatic int bitrev(input int v, input int l);
        int r;
        r = 0;
        for (int b = 0; b < l; b++) begin
            r = r * 2 + ((v >> b) & 1);
        end
        return r;
    endfunction

    task automatic check_overrun();
`ifdef FFT_SEQ_OVERRUN_EN
        chk("overrun_cnt", int'(overrun_cnt), ovr_model);
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_status", int'(status), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_load_we", int'(load_we), 0);
        chk("rst_load_addr", int'(load_addr), 0);
        chk("rst_stage_start", int'(stage_start), 0);
        chk("rst_stage_idx", int'(stage_idx), 0);
        chk("rst_log2n", int'(log2n), MIN_LOG2N);
        chk("rst_bfp_clr", int'(bfp_clr), 0);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        check_overrun();
    endtask

    // Release reset at a falling edge, then expect one IDLE cycle and LOAD.
    task automatic release_reset(input int exp_l);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_idle", int'(status), 0);
        @(negedge clk);
        #1;
        chk("post_rst_load", int'(status), 1);
        chk("post_rst_log2n", int'(log2n), exp_l);
        chk("post_rst_fc", int'(frame_count), 0);
    endtask

    // Offer n samples (optionally with idle gaps) and check each write address.
    task automatic load_frame(input int l, input bit gaps, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    #1;
                    chk("gap_load_we", int'(load_we), 0);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            chk("load_we", int'(load_we), 1);
            chk("load_addr", int'(load_addr), bitrev(i, l));
            if (i == 0) begin
                chk("load_in_ready", int'(in_ready), 1);
                chk("load_status", int'(status), 1);
                chk("load_log2n", int'(log2n), l);
            end
        end
    endtask

    // Play AGU/butterfly: agu_done d_agu cycles after each stage_start, busy
    // drops d_busy cycles after that. Returns early at stage stop_stage.
    task automatic run_frame(input int l, input int d_agu, input int d_busy,
                             input bit noise, input int stop_stage);
        int starts;
        int clrs;
        int t;
        int cyc;
        bit done_seen;
        starts = 0;
        clrs = 0;
        t = -1;
        cyc = 0;
        done_seen = 1'b0;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (status == 3'd3) begin
                done_seen = 1'b1;
                agu_done = 1'b0;
                bfly_busy = 1'b0;
                in_valid = 1'b0;
                break;
            end
            if (stage_start) begin
                chk("stage_idx", int'(stage_idx), starts);
                starts++;
                t = 0;
            end else if (t >= 0) begin
                t++;
            end
            if (bfp_clr) clrs++;
            if (stop_stage >= 0 && stage_start && (starts - 1) == stop_stage) begin
                agu_done = 1'b0;
                bfly_busy = 1'b1;
                in_valid = 1'b0;
                return;
            end
            agu_done = (t == d_agu);
            bfly_busy = (t >= 0) && (t < d_agu + d_busy);
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (in_valid) ovr_model++;
            #1;
            chk("fft_load_we", int'(load_we), 0);
            chk("fft_in_ready", int'(in_ready), 0);
            chk("fft_status", int'(status), 2);
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("stage_starts", starts, l);
        chk("bfp_clrs", clrs, l);
        chk("done_result_valid", int'(result_valid), 1);
        chk("done_frame_count", int'(frame_count), fc_model % 256);
        check_overrun();
    endtask

    // Linger in DONE with ignored samples, then ack with a new length.
    task automatic done_and_ack(input int new_cfg);
        int linger;
        linger = int'($urandom_range(0, 3));
        for (int k = 0; k < linger; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            if (in_valid) ovr_model++;
            #1;
            chk("done_rv", int'(result_valid), 1);
            chk("done_status", int'(status), 3);
            chk("done_load_we", int'(load_we), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        result_ack = 1'b1;
        cfg_log2n = STAGE_W'(new_cfg);
        @(negedge clk);
        result_ack = 1'b0;
        fc_model++;
        #1;
        chk("ack_status", int'(status), 1);
        chk("ack_rv", int'(result_valid), 0);
        chk("ack_frame_count", int'(frame_count), fc_model % 256);
        chk("ack_log2n", int'(log2n), clampl(new_cfg));
    endtask

    // Abort, expect IDLE with cleared stage index and held frame count, then LOAD.
    task automatic abort_rearm(input int cfg);
        @(negedge clk);
        abort = 1'b1;
        in_valid = 1'b0;
        agu_done = 1'b0;
        bfly_busy = 1'b0;
        cfg_log2n = STAGE_W'(cfg);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_idle", int'(status), 0);
        chk("abort_stage_idx", int'(stage_idx), 0);
        chk("abort_fc_held", int'(frame_count), fc_model % 256);
        chk("abort_rv", int'(result_valid), 0);
        @(negedge clk);
        #1;
        chk("abort_rearm_load", int'(status), 1);
    endtask

    typedef struct {
        int cfg;
        int exp_l;
        int exp_addr1;
    } clamp_vec_t;

    initial begin
        clamp_vec_t vecs[10];
        int l;
        int c;

        vecs[0] = '{0, 3, 4};
        vecs[1] = '{1, 3, 4};
        vecs[2] = '{2, 3, 4};
        vecs[3] = '{3, 3, 4};
        vecs[4] = '{4, 4, 8};
        vecs[5] = '{7, 7, 64};
        vecs[6] = '{10, 10, 512};
        vecs[7] = '{11, 10, 512};
        vecs[8] = '{15, 10, 512};
        vecs[9] = '{5, 5, 16};

        rst = 1'b1;
        abort = 1'b0;
        cfg_log2n = 4'd3;
        in_valid = 1'b0;
        agu_done = 1'b0;
        bfly_busy = 1'b0;
        result_ack = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        release_reset(3);

        // 8-point frame, back-to-back samples, AGU 4 cycles, busy 2 more.
        load_frame(3, 1'b0, 8);
        run_frame(3, 4, 2, 1'b0, -1);
        done_and_ack(4);
        load_frame(4, 1'b0, 16);
        run_frame(4, 2, 1, 1'b1, -1);
        done_and_ack(15);
        load_frame(10, 1'b0, 1024);
        run_frame(10, 1, 0, 1'b1, -1);
        done_and_ack(1);
        load_frame(3, 1'b1, 8);
        run_frame(3, 0, 3, 1'b1, -1);

        // Clamp table, armed through abort; also check the second address.
        for (int v = 0; v < 10; v++) begin
            abort_rearm(vecs[v].cfg);
            chk("clamp_log2n", int'(log2n), vecs[v].exp_l);
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            chk("clamp_addr0", int'(load_addr), 0);
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            chk("clamp_addr1", int'(load_addr), vecs[v].exp_addr1);
        end

        // Abort mid-load restarts the sample counter.
        abort_rearm(5);
        load_frame(5, 1'b0, 7);
        abort_rearm(5);
        load_frame(5, 1'b1, 32);
        run_frame(5, 3, 2, 1'b0, -1);
        done_and_ack(6);

        // Abort during RUN stage 1.
        load_frame(6, 1'b0, 64);
        run_frame(6, 2, 2, 1'b0, 1);
        abort_rearm(4);
        l = 4;

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            load_frame(l, 1'b1, 1 << l);
            run_frame(l, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1, -1);
            c = int'($urandom_range(0, 15));
            if (r > 2 && c > 7) c = c - 8;
            done_and_ack(c);
            l = clampl(c);
        end

        // Reset during RUN, stage 2.
        load_frame(l, 1'b0, 1 << l);
        run_frame(l, 3, 1, 1'b0, 2);
        #2;
        rst = 1'b0;
        fc_model = 0;
        ovr_model = 0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs();
        cfg_log2n = 4'd3;
        release_reset(3);

        // Five offered samples while in RUN are dropped.
        load_frame(3, 1'b0, 8);
        run_frame(3, 2, 1, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ovr_model++;
            #1;
            chk("run_drop_we", int'(load_we), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("run_hold_status", int'(status), 2);
        check_overrun();
        abort_rearm(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
